// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP-1 control path.
//   - opcode encodings (OP_*)
//   - one-hot ring state encodings (T1..T6)
//   - control-word bit indices (CW_*), shared with datapath and bench
//   - is_onehot(): legality check for the ring register
package sap_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned RING_W = 6;

  localparam logic [OPC_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  localparam logic [RING_W-1:0] T1 = 6'b000001;
  localparam logic [RING_W-1:0] T2 = 6'b000010;
  localparam logic [RING_W-1:0] T3 = 6'b000100;
  localparam logic [RING_W-1:0] T4 = 6'b001000;
  localparam logic [RING_W-1:0] T5 = 6'b010000;
  localparam logic [RING_W-1:0] T6 = 6'b100000;

  // Control-word bit positions
  localparam int unsigned CW_W           = 12;
  localparam int unsigned CW_PC_INC      = 0;
  localparam int unsigned CW_PC_OUT      = 1;
  localparam int unsigned CW_MAR_LOAD    = 2;
  localparam int unsigned CW_RAM_OUT     = 3;
  localparam int unsigned CW_IR_LOAD     = 4;
  localparam int unsigned CW_IR_ADDR_OUT = 5;
  localparam int unsigned CW_A_LOAD      = 6;
  localparam int unsigned CW_A_OUT       = 7;
  localparam int unsigned CW_B_LOAD      = 8;
  localparam int unsigned CW_ALU_SUB     = 9;
  localparam int unsigned CW_ALU_OUT     = 10;
  localparam int unsigned CW_OUT_LOAD    = 11;

  typedef logic [CW_W-1:0] cw_t;

  function automatic logic is_onehot(input logic [RING_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < RING_W; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// ring_counter: 6-bit one-hot T-state ring.
//   i_clock  : clock, rising edge
//   i_reset  : async active-high, forces T1
//   hold_i   : freeze current state
//   state_o  : one-hot ring state
// A non-one-hot value is replaced by T1 on the next edge, regardless of hold.
module ring_counter
  import sap_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              hold_i,
  output logic [RING_W-1:0] state_o
);

  logic [RING_W-1:0] state_q;
  logic [RING_W-1:0] state_d;

  always_comb begin
    state_d = {state_q[RING_W-2:0], state_q[RING_W-1]};
    if (!is_onehot(state_q)) state_d = T1;
    else if (hold_i)         state_d = state_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= T1;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 control unit.
//   i_clock, i_reset (async active-high), i_opcode (IR opcode, valid T4..T6)
//   o_t_state        : one-hot ring state, bit0=T1
//   o_pc_increment, o_pc_out, o_mar_load, o_ram_out, o_ir_load,
//   o_ir_address_out, o_a_load, o_a_out, o_b_load, o_alu_subtract,
//   o_alu_out, o_out_load : active-high datapath strobes
//   o_halt           : machine halted (until reset)
// Strobes decode combinationally from ring state, opcode and the halt flag.
module controller_sequencer
  import sap_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [OPC_W-1:0]  i_opcode,
  output logic [RING_W-1:0] o_t_state,
  output logic              o_pc_increment,
  output logic              o_pc_out,
  output logic              o_mar_load,
  output logic              o_ram_out,
  output logic              o_ir_load,
  output logic              o_ir_address_out,
  output logic              o_a_load,
  output logic              o_a_out,
  output logic              o_b_load,
  output logic              o_alu_subtract,
  output logic              o_alu_out,
  output logic              o_out_load,
  output logic              o_halt
);

  logic [RING_W-1:0] t_state;
  logic              halt_q;
  logic              halt_d;
  cw_t               cw;

  // HLT in T4 sets the flag on the closing edge; the ring must not advance on
  // that same edge, so the hold uses the next-state value.
  assign halt_d = halt_q | ((t_state == T4) && (i_opcode == OP_HLT));

  ring_counter u_ring (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .hold_i  (halt_d),
    .state_o (t_state)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) halt_q <= 1'b0;
    else         halt_q <= halt_d;
  end

  always_comb begin
    cw = '0;
    if (!halt_q) begin
      case (t_state)
        T1: begin
          cw[CW_PC_OUT]   = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_IR_LOAD] = 1'b1;
        end
        T4: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CW_IR_ADDR_OUT] = 1'b1;
              cw[CW_MAR_LOAD]    = 1'b1;
            end
            OP_OUT: begin
              cw[CW_A_OUT]    = 1'b1;
              cw[CW_OUT_LOAD] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (i_opcode)
            OP_LDA: begin
              cw[CW_RAM_OUT] = 1'b1;
              cw[CW_A_LOAD]  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RAM_OUT] = 1'b1;
              cw[CW_B_LOAD]  = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            cw[CW_ALU_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = (i_opcode == OP_SUB);
          end
        end
        // non-one-hot ring: everything stays low
        default: ;
      endcase
    end
  end

  assign o_t_state        = t_state;
  assign o_halt           = halt_q;
  assign o_pc_increment   = cw[CW_PC_INC];
  assign o_pc_out         = cw[CW_PC_OUT];
  assign o_mar_load       = cw[CW_MAR_LOAD];
  assign o_ram_out        = cw[CW_RAM_OUT];
  assign o_ir_load        = cw[CW_IR_LOAD];
  assign o_ir_address_out = cw[CW_IR_ADDR_OUT];
  assign o_a_load         = cw[CW_A_LOAD];
  assign o_a_out          = cw[CW_A_OUT];
  assign o_b_load         = cw[CW_B_LOAD];
  assign o_alu_subtract   = cw[CW_ALU_SUB];
  assign o_alu_out        = cw[CW_ALU_OUT];
  assign o_out_load       = cw[CW_OUT_LOAD];

endmodule
